rr_prio_arbiter_fsm: RTL and testbench

//   Registered N-requester grant FSM for shared-resource arbitration.

---
 rtl/rr_prio_arbiter_fsm_pkg.sv | 25 ++
 rtl/rr_prio_arbiter_fsm_pick_first.sv | 35 +++
 rtl/rr_prio_arbiter_fsm.sv | 134 +++++++++++++
 tb/tb_rr_prio_arbiter_fsm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_prio_arbiter_fsm_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg : shared types and helpers for the round-robin/priority arbiter
// Rev 1.0
// ============================================================================
package arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Widest requester vector the helper below can encode.
  localparam int ARB_MAX_N = 32;

  function automatic logic [ARB_MAX_N-1:0] onehot_idx(input int unsigned idx,
                                                      input int unsigned n);
    logic [ARB_MAX_N-1:0] v;
    v = '0;
    if (idx < n && idx < ARB_MAX_N) v[idx[4:0]] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_prio_arbiter_fsm_pick_first.sv
`default_nettype none
// ============================================================================
// arb_pick_first : combinational rotating first-one finder
// Rev 1.0
// ============================================================================
module arb_pick_first
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] start,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  // Scan from the far end back toward start so the closest hit wins last.
  always_comb begin
    logic [IW-1:0] pos;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = IW'((int'(start) + i) % N);
      if (vec[pos]) begin
        idx   = pos;
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_prio_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// rr_prio_arbiter_fsm : registered N-requester grant FSM, fixed or RR, hold limit
// Rev 1.0
// ============================================================================
module rr_prio_arbiter_fsm
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         r,
  output logic [N-1:0]         g,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic                 timeout
);

  localparam int            IW        = $clog2(N);
  localparam int            HW        = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  g_q, g_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          mask_q, mask_d;
  logic          timeout_q, timeout_d;

  logic [ARB_MAX_N-1:0] own_oh_full, last_oh_full, win_oh_full;
  logic [N-1:0]         others, masked, cand;
  logic [IW-1:0]        start_idx, win_idx;
  logic                 win_valid;

  assign own_oh_full  = onehot_idx(32'(owner_q), N);
  assign last_oh_full = onehot_idx(32'(last_q), N);
  assign win_oh_full  = onehot_idx(32'(win_idx), N);

  generate
    if (N < ARB_MAX_N) begin : g_oh_pad
      logic unused_oh_bits;
      assign unused_oh_bits = ^{own_oh_full[ARB_MAX_N-1:N],
                                last_oh_full[ARB_MAX_N-1:N],
                                win_oh_full[ARB_MAX_N-1:N]};
    end
  endgenerate

  assign others = r & ~own_oh_full[N-1:0];
  assign masked = r & ~last_oh_full[N-1:0];
  // A timed-out owner steps aside once, unless it is the only requester left.
  assign cand   = (mask_q && (masked != '0)) ? masked : r;

  assign start_idx = (RR_MODE == ARB_RR)
                   ? ((last_q == LAST_IDX) ? '0 : last_q + 1'b1)
                   : '0;

  arb_pick_first #(.N(N)) u_pick (
    .vec   (cand),
    .start (start_idx),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    mask_d    = mask_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        mask_d = 1'b0;
        if (win_valid) begin
          state_d = ARB_GRANT;
          g_d     = win_oh_full[N-1:0];
          owner_d = win_idx;
          last_d  = win_idx;
          hold_d  = '0;
        end
      end
      ARB_GRANT: begin
        if (!r[owner_q]) begin
          state_d = ARB_IDLE;
          g_d     = '0;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (others != '0)) begin
          state_d   = ARB_IDLE;
          g_d       = '0;
          timeout_d = 1'b1;
          mask_d    = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        g_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ARB_IDLE;
      g_q       <= '0;
      owner_q   <= '0;
      last_q    <= LAST_IDX;
      hold_q    <= '0;
      mask_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end

  assign g       = g_q;
  assign busy    = |g_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_prio_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// tb_rr_prio_arbiter_fsm : three arbiter configurations against a cycle model
// Rev 1.0
// ============================================================================
module tb_rr_prio_arbiter_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] req [3];
  logic [3:0] gnt [3];
  logic       bsy [3];
  logic [1:0] own [3];
  logic       tmo [3];

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: fixed, unlimited. 1: fixed, hold 3. 2: round-robin, hold 2.
  int mode_cfg [3] = '{0, 0, 1};
  int mh_cfg   [3] = '{0, 3, 2};

  always #5 clk = ~clk;

  rr_prio_arbiter_fsm #(.N(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix0 (
    .clk(clk), .resetn(resetn), .r(req[0]), .g(gnt[0]), .busy(bsy[0]),
    .owner(own[0]), .timeout(tmo[0]));
  rr_prio_arbiter_fsm #(.N(4), .RR_MODE(0), .MAX_HOLD(3)) u_fix3 (
    .clk(clk), .resetn(resetn), .r(req[1]), .g(gnt[1]), .busy(bsy[1]),
    .owner(own[1]), .timeout(tmo[1]));
  rr_prio_arbiter_fsm #(.N(4), .RR_MODE(1), .MAX_HOLD(2)) u_rr2 (
    .clk(clk), .resetn(resetn), .r(req[2]), .g(gnt[2]), .busy(bsy[2]),
    .owner(own[2]), .timeout(tmo[2]));

  // Reference: who holds the resource, for how many cycles, and who must yield.
  logic [3:0] m_g     [3];
  int         m_owner [3];
  int         m_last  [3];
  int         m_excl  [3];
  int         m_held  [3];
  logic       m_to    [3];

  function automatic void model_step(input int k, input logic [3:0] rq);
    int cur;
    int w;
    int ix;
    logic [3:0] cand;
    m_to[k] = 1'b0;
    if (!resetn) begin
      m_g[k] = 4'b0000; m_owner[k] = 0; m_last[k] = 3; m_excl[k] = -1; m_held[k] = 0;
      return;
    end
    if (m_g[k] != 4'b0000) begin
      cur = m_owner[k];
      if (!rq[cur]) begin
        m_g[k] = 4'b0000;
      end else if (mh_cfg[k] > 0 && m_held[k] >= mh_cfg[k] &&
                   (rq & ~(4'b0001 << cur)) != 4'b0000) begin
        m_g[k] = 4'b0000; m_to[k] = 1'b1; m_excl[k] = cur;
      end else begin
        m_held[k] = m_held[k] + 1;
      end
    end else begin
      cand = rq;
      if (m_excl[k] >= 0 && (rq & ~(4'b0001 << m_excl[k])) != 4'b0000)
        cand = rq & ~(4'b0001 << m_excl[k]);
      m_excl[k] = -1;
      w = -1;
      for (int s = 0; s < 4; s++) begin
        ix = (mode_cfg[k] == 1) ? (m_last[k] + 1 + s) % 4 : s;
        if (w < 0 && cand[ix]) w = ix;
      end
      if (w >= 0) begin
        m_g[k] = 4'b0001 << w; m_owner[k] = w; m_last[k] = w; m_held[k] = 1;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k, req[k]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) req[k] = 4'b0000;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) req[k] = 4'b1111;
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (gnt[k] !== 4'b0000 || bsy[k] !== 1'b0 || tmo[k] !== 1'b0 || own[k] !== 2'd0) begin
          miscompares++;
          $display("FAIL reset inst=%0d got g=%b busy=%b to=%b owner=%0d exp g=0000 busy=0 to=0 owner=0",
                   k, gnt[k], bsy[k], tmo[k], own[k]);
        end
      end
    end
    resetn = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (gnt[k] !== 4'b0001 || bsy[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_release inst=%0d got g=%b busy=%b exp g=0001 busy=1", k, gnt[k], bsy[k]);
      end
    end
  endtask

  task automatic test_fixed_hold();
    do_reset();
    req[0] = 4'b1110;
    for (int c = 0; c < 6; c++) begin
      step();
      vectors++;
      if (gnt[0] !== 4'b0010 || own[0] !== 2'd1) begin
        miscompares++;
        $display("FAIL fixed_hold cyc=%0d got g=%b owner=%0d exp g=0010 owner=1", c, gnt[0], own[0]);
      end
    end
    req[0] = 4'b1100;
    step();
    vectors++;
    if (gnt[0] !== 4'b0000 || bsy[0] !== 1'b0 || own[0] !== 2'd1) begin
      miscompares++;
      $display("FAIL fixed_gap got g=%b busy=%b owner=%0d exp g=0000 busy=0 owner=1", gnt[0], bsy[0], own[0]);
    end
    step();
    vectors++;
    if (gnt[0] !== 4'b0100 || own[0] !== 2'd2) begin
      miscompares++;
      $display("FAIL fixed_next got g=%b owner=%0d exp g=0100 owner=2", gnt[0], own[0]);
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp_g [15] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                               4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2};
    do_reset();
    req[1] = 4'b0011;
    for (int c = 0; c < 15; c++) begin
      step();
      vectors++;
      if (gnt[1] !== exp_g[c] || tmo[1] !== (exp_g[c] == 4'h0)) begin
        miscompares++;
        $display("FAIL hold_limit cyc=%0d got g=%b to=%b exp g=%b to=%b",
                 c, gnt[1], tmo[1], exp_g[c], (exp_g[c] == 4'h0));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                               4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    logic [1:0] exp_o [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                               2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    do_reset();
    req[2] = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      step();
      vectors++;
      if (gnt[2] !== exp_g[c] || own[2] !== exp_o[c] || tmo[2] !== (exp_g[c] == 4'h0)) begin
        miscompares++;
        $display("FAIL round_robin cyc=%0d got g=%b owner=%0d to=%b exp g=%b owner=%0d to=%b",
                 c, gnt[2], own[2], tmo[2], exp_g[c], exp_o[c], (exp_g[c] == 4'h0));
      end
    end
  endtask

  task automatic test_no_contention();
    do_reset();
    req[1] = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (gnt[1] !== 4'b0001 || tmo[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL no_contention cyc=%0d got g=%b to=%b exp g=0001 to=0", c, gnt[1], tmo[1]);
      end
    end
  endtask

  task automatic test_rr_reset();
    do_reset();
    req[2] = 4'b1111;
    repeat (7) step();
    vectors++;
    if (gnt[2] !== 4'b0100 || own[2] !== 2'd2) begin
      miscompares++;
      $display("FAIL rr_reset_pre got g=%b owner=%0d exp g=0100 owner=2", gnt[2], own[2]);
    end
    resetn = 1'b0;
    step();
    vectors++;
    if (gnt[2] !== 4'b0000 || own[2] !== 2'd0 || bsy[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_reset_mid got g=%b owner=%0d busy=%b exp g=0000 owner=0 busy=0",
               gnt[2], own[2], bsy[2]);
    end
    resetn = 1'b1;
    step();
    vectors++;
    if (gnt[2] !== 4'b0001 || own[2] !== 2'd0) begin
      miscompares++;
      $display("FAIL rr_reset_post got g=%b owner=%0d exp g=0001 owner=0", gnt[2], own[2]);
    end
  endtask

  task automatic test_random();
    logic prev_to [3];
    do_reset();
    for (int k = 0; k < 3; k++) prev_to[k] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 3) == 0) req[k] = 4'($urandom_range(0, 15));
      resetn = ($urandom_range(0, 59) != 0);
      step();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (gnt[k] !== m_g[k] || own[k] !== 2'(m_owner[k]) || tmo[k] !== m_to[k] ||
            bsy[k] !== (m_g[k] != 4'b0000)) begin
          miscompares++;
          $display("FAIL random cyc=%0d inst=%0d got g=%b owner=%0d to=%b busy=%b exp g=%b owner=%0d to=%b",
                   c, k, gnt[k], own[k], tmo[k], bsy[k], m_g[k], m_owner[k], m_to[k]);
        end
        vectors++;
        if (!$onehot0(gnt[k]) || (prev_to[k] && tmo[k])) begin
          miscompares++;
          $display("FAIL invariant cyc=%0d inst=%0d got g=%b to=%b prev_to=%b exp onehot0 g, no double timeout",
                   c, k, gnt[k], tmo[k], prev_to[k]);
        end
        prev_to[k] = tmo[k];
      end
    end
    resetn = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) req[k] = 4'b0000;
    test_reset();
    test_fixed_hold();
    test_hold_limit();
    test_round_robin();
    test_no_contention();
    test_rr_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
